// File: rtl/qerv_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qerv_bus_pkg
// Purpose  : Shared definitions for the qerv data-bus responder: timer
//            address map, responder FSM state encoding and a byte-merge helper.
// Revision : 1.0 - initial release
// ============================================================================
package qerv_bus_pkg;

    // Address bit that selects the timer window instead of RAM
    localparam int TIMER_BIT = 31;

    // Timer register offsets, decoded on adr[3:2]
    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_REST = 2'd3
    } bus_state_t;

    // Replace the bytes of old_word whose enable bit is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qerv_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : qerv_mtimer
// Purpose  : 64-bit machine timer (mtime/mtimecmp) with prescaler,
//            byte-masked bus write port and registered level interrupt.
// Ports    : clk, rst_n      - clock, async active-low reset
//            wr_en           - commit a bus write this cycle
//            wr_reg          - target register (adr[3:2])
//            wr_sel, wr_dat  - byte enables and write data
//            mtime, mtimecmp - current register values (for bus reads)
//            irq             - mtime >= mtimecmp, registered
// Revision : 1.0 - initial release
// ============================================================================
module qerv_mtimer
    import qerv_bus_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_reg,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_dat,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [63:0]   time_inc;
    logic [63:0]   time_nxt;
    logic [63:0]   cmp_nxt;

    assign tick     = (presc == PW'(PRESCALE - 1));
    assign time_inc = mtime + 64'd1;

    always_comb begin
        time_nxt = tick ? time_inc : mtime;
        cmp_nxt  = mtimecmp;
        if (wr_en) begin
            case (wr_reg)
                // A low-word write suppresses the carry into the high word;
                // unwritten low bytes still follow the increment.
                MTIME_LO:    time_nxt = {mtime[63:32],
                                         merge_bytes(time_nxt[31:0], wr_dat, wr_sel)};
                MTIME_HI:    time_nxt = {merge_bytes(time_nxt[63:32], wr_dat, wr_sel),
                                         time_nxt[31:0]};
                MTIMECMP_LO: cmp_nxt  = {mtimecmp[63:32],
                                         merge_bytes(mtimecmp[31:0], wr_dat, wr_sel)};
                MTIMECMP_HI: cmp_nxt  = {merge_bytes(mtimecmp[63:32], wr_dat, wr_sel),
                                         mtimecmp[31:0]};
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq      <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            mtime    <= time_nxt;
            mtimecmp <= cmp_nxt;
            // Compares the current registers, so the level follows any
            // operand change by one cycle.
            irq      <= (mtime >= mtimecmp);
        end
    end

endmodule
`default_nettype wire

// File: rtl/qerv_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : qerv_dbus_responder
// Purpose  : Wishbone-style data-bus responder for the qerv core: byte-enabled
//            word RAM, machine timer with interrupt, configurable wait states.
// Ports    : i_clk, i_rst_n         - clock, async active-low reset
//            i_dbus_adr/dat/sel/we  - request address, data, byte enables, dir
//            i_dbus_cyc             - request valid, held until ack
//            o_dbus_rdt             - read data, updated in the ack cycle
//            o_dbus_ack             - one-cycle acknowledge
//            o_timer_irq            - timer interrupt level
// Revision : 1.0 - initial release
// ============================================================================
module qerv_dbus_responder
    import qerv_bus_pkg::*;
#(
    parameter int DEPTH    = 4096,
    parameter int WAIT     = 0,
    parameter int PRESCALE = 1,
    parameter     MEMFILE  = ""
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_timer_irq
);

    localparam int WORDS = DEPTH / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [WORDS];

    bus_state_t  state;
    logic [3:0]  wait_cnt;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic [31:0] cur_adr;
    logic [31:0] cur_dat;
    logic [3:0]  cur_sel;
    logic        cur_we;
    logic [IW-1:0] word_idx;
    logic        is_timer;
    logic        wait_last;
    logic        go_ack;
    logic        ram_we;
    logic        tmr_we;
    logic [31:0] timer_rd;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        unused;

    // With no wait states the transfer completes straight from IDLE, so the
    // live bus is used there; afterwards the latched copy is authoritative,
    // which keeps the transfer intact if cyc drops early.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_adr = i_dbus_adr;
            cur_dat = i_dbus_dat;
            cur_sel = i_dbus_sel;
            cur_we  = i_dbus_we;
        end else begin
            cur_adr = adr_q;
            cur_dat = dat_q;
            cur_sel = sel_q;
            cur_we  = we_q;
        end
    end

    // Upper address bits are masked off so the RAM aliases across the space
    assign word_idx  = IW'(cur_adr[31:2]) & IW'(WORDS - 1);
    assign is_timer  = cur_adr[TIMER_BIT];
    assign wait_last = (wait_cnt == 4'(WAIT - 1));

    // Gated by reset so nothing commits while reset is held
    assign go_ack = i_rst_n &
                    (((state == ST_IDLE) && i_dbus_cyc && (WAIT == 0)) ||
                     ((state == ST_WAIT) && wait_last));

    assign ram_we = go_ack & cur_we & ~is_timer;
    assign tmr_we = go_ack & cur_we &  is_timer;

    always_comb begin
        case (cur_adr[3:2])
            MTIME_LO:    timer_rd = mtime[31:0];
            MTIME_HI:    timer_rd = mtime[63:32];
            MTIMECMP_LO: timer_rd = mtimecmp[31:0];
            default:     timer_rd = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            we_q       <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_dbus_rdt <= 32'd0;
        end else begin
            o_dbus_ack <= go_ack;
            if (go_ack && !cur_we) begin
                o_dbus_rdt <= is_timer ? timer_rd : mem[word_idx];
            end
            case (state)
                ST_IDLE: begin
                    if (i_dbus_cyc) begin
                        adr_q    <= i_dbus_adr;
                        dat_q    <= i_dbus_dat;
                        sel_q    <= i_dbus_sel;
                        we_q     <= i_dbus_we;
                        wait_cnt <= 4'd0;
                        state    <= (WAIT == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_last) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK:  state <= ST_REST;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[word_idx][8*b +: 8] <= cur_dat[8*b +: 8];
                end
            end
        end
    end

    qerv_mtimer #(
        .PRESCALE (PRESCALE)
    ) u_mtimer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .wr_en    (tmr_we),
        .wr_reg   (cur_adr[3:2]),
        .wr_sel   (cur_sel),
        .wr_dat   (cur_dat),
        .mtime    (mtime),
        .mtimecmp (mtimecmp),
        .irq      (o_timer_irq)
    );

    assign unused = &{1'b0, cur_adr};

endmodule
`default_nettype wire
